// File: rtl/cnn_stimulus_sequencer_pkg.sv
// cnn_stimulus_sequencer_pkg: shared defaults, state type and width helper for the CNN test sequencer.
package cnn_stimulus_sequencer_pkg;
    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int F_IN_W1 = 28;
    localparam int F_IN_H1 = 28;
    localparam int CNN_NUM_CLASSES = 10;
    localparam int CNN_NUM_TEST_IMAGES = 4;
    localparam int CNN_STARTUP_CYCLES = 300;
    localparam int CNN_TIMEOUT_CYCLES = 65535;
    typedef enum logic [2:0] {IDLE, WAIT, STREAM, PRED, EVAL, REPORT, DONE} seq_state_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cnn_stimulus_sequencer_argmax.sv
// cnn_argmax: signed argmax over a score vector; strict compare keeps the lowest index on ties.
module cnn_argmax
    import cnn_stimulus_sequencer_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W = 8
) (
    input  logic [NUM_CLASSES-1:0][DATA_W-1:0]  scores,
    output logic [clog2_min1(NUM_CLASSES)-1:0]  idx
);
    logic signed [DATA_W-1:0] best;
    always_comb begin
        idx = '0;
        best = scores[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if ($signed(scores[i]) > best) begin
                idx = $bits(idx)'(i);
                best = scores[i];
            end
        end
    end
endmodule

// File: rtl/cnn_stimulus_sequencer_rom.sv
// cnn_stimulus_sequencer_rom: parameter-initialised ROM with one-cycle registered, enable-gated read.
module cnn_stimulus_sequencer_rom
    import cnn_stimulus_sequencer_pkg::*;
#(
    parameter int W = 8,
    parameter int DEPTH = 4,
    parameter logic [DEPTH*W-1:0] INIT = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en,
    input  logic [clog2_min1(DEPTH)-1:0] addr,
    output logic [W-1:0]                 dout
);
    logic [W-1:0] mem [DEPTH];
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem[i] = INIT[i*W +: W];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dout <= '0;
        else if (en) dout <= mem[addr];
    end
endmodule

// File: rtl/cnn_stimulus_sequencer.sv
// cnn_stimulus_sequencer: streams ROM images into the CNN, scores each prediction against a label ROM
// and keeps saturating pass/fail counts; optionally loops for soak testing.
module cnn_stimulus_sequencer
    import cnn_stimulus_sequencer_pkg::*;
#(
    parameter int DATA_W = FEATURE_MAP_RESOLUTION,
    parameter int NUM_CH = 1,
    parameter int PIXELS = F_IN_W1 * F_IN_H1,
    parameter int NUM_IMAGES = CNN_NUM_TEST_IMAGES,
    parameter int NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int STARTUP_CYCLES = CNN_STARTUP_CYCLES,
    parameter int TIMEOUT_CYCLES = CNN_TIMEOUT_CYCLES,
    parameter logic [NUM_IMAGES*PIXELS*NUM_CH*DATA_W-1:0] IMG_INIT = '0,
    parameter logic [NUM_IMAGES*clog2_min1(NUM_CLASSES)-1:0] LBL_INIT = '0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic                                   loop_en_i,
    output logic                                   cnn_input_valid_o,
    output logic [NUM_CH-1:0][DATA_W-1:0]          cnn_input_data_o,
    output logic [clog2_min1(PIXELS)-1:0]          cnn_input_addr_o,
    input  logic                                   cnn_input_ready_i,
    input  logic                                   cnn_prediction_valid_i,
    input  logic [NUM_CLASSES-1:0][DATA_W-1:0]     cnn_prediction_data_i,
    output logic                                   cnn_prediction_ready_o,
    output logic                                   result_valid_o,
    output logic [clog2_min1(NUM_CLASSES)-1:0]     result_class_o,
    output logic                                   result_pass_o,
    output logic [clog2_min1(NUM_IMAGES)-1:0]      result_img_o,
    input  logic                                   result_ready_i,
    output logic [15:0]                            pass_count_o,
    output logic [15:0]                            fail_count_o,
    output logic                                   timeout_o,
    output logic                                   busy_o,
    output logic                                   done_o
);
    localparam int PW = clog2_min1(PIXELS);
    localparam int IW = clog2_min1(NUM_IMAGES);
    localparam int CW = clog2_min1(NUM_CLASSES);
    localparam int AW = clog2_min1(NUM_IMAGES * PIXELS);

    seq_state_t state, state_nx;
    logic [31:0] cnt;
    logic [PW:0] iss;
    logic [IW-1:0] img;
    logic [AW-1:0] rom_addr;
    logic [NUM_CLASSES-1:0][DATA_W-1:0] scores;
    logic [CW-1:0] amax, label;
    logic ren, issue, last_acc, pred_acc, res_acc, last_img, wait_done, timed_out, start_ok;

    // Output register only advances when empty or drained, giving one pixel per cycle under ready.
    assign ren = (state == STREAM) & (~cnn_input_valid_o | cnn_input_ready_i);
    assign issue = ren & (iss < (PW+1)'(PIXELS));
    assign rom_addr = AW'(img * PIXELS + iss);
    assign last_acc = cnn_input_valid_o & cnn_input_ready_i & (cnn_input_addr_o == PW'(PIXELS - 1));
    assign pred_acc = cnn_prediction_valid_i & cnn_prediction_ready_o;
    assign res_acc = result_valid_o & result_ready_i;
    assign last_img = img == IW'(NUM_IMAGES - 1);
    assign wait_done = cnt + 32'd1 >= 32'(STARTUP_CYCLES);
    assign timed_out = cnt + 32'd1 >= 32'(TIMEOUT_CYCLES);
    assign start_ok = start_i & ((state == IDLE) | (state == DONE));

    assign cnn_prediction_ready_o = state == PRED;
    assign result_valid_o = state == REPORT;
    assign result_img_o = img;
    assign busy_o = (state != IDLE) & (state != DONE);
    assign done_o = state == DONE;

    cnn_stimulus_sequencer_rom #(.W(NUM_CH * DATA_W), .DEPTH(NUM_IMAGES * PIXELS), .INIT(IMG_INIT)) u_img_rom (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en    (issue),
        .addr  (rom_addr),
        .dout  (cnn_input_data_o)
    );

    cnn_stimulus_sequencer_rom #(.W(CW), .DEPTH(NUM_IMAGES), .INIT(LBL_INIT)) u_lbl_rom (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en    (1'b1),
        .addr  (img),
        .dout  (label)
    );

    cnn_argmax #(.NUM_CLASSES(NUM_CLASSES), .DATA_W(DATA_W)) u_argmax (
        .scores(scores),
        .idx   (amax)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start_i ? WAIT : state;
            WAIT:       state_nx = wait_done ? STREAM : WAIT;
            STREAM:     state_nx = last_acc ? PRED : STREAM;
            PRED:       state_nx = pred_acc ? EVAL : timed_out ? REPORT : PRED;
            EVAL:       state_nx = REPORT;
            REPORT:     state_nx = !res_acc ? REPORT : !last_img ? STREAM : loop_en_i ? WAIT : DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            iss <= '0;
            img <= '0;
            scores <= '0;
            cnn_input_valid_o <= 1'b0;
            cnn_input_addr_o <= '0;
            result_class_o <= '0;
            result_pass_o <= 1'b0;
            pass_count_o <= '0;
            fail_count_o <= '0;
            timeout_o <= 1'b0;
        end else begin
            cnt <= (state_nx != state) ? '0 : cnt + 32'd1;
            if (state_nx == STREAM && state != STREAM) iss <= '0;
            if (issue) begin
                cnn_input_valid_o <= 1'b1;
                cnn_input_addr_o <= PW'(iss);
                iss <= iss + 1'b1;
            end else if (ren) begin
                cnn_input_valid_o <= 1'b0;
            end
            if (start_ok) begin
                img <= '0;
                pass_count_o <= '0;
                fail_count_o <= '0;
                timeout_o <= 1'b0;
            end
            if (state == PRED && pred_acc) begin
                scores <= cnn_prediction_data_i;
            end else if (state == PRED && timed_out) begin
                timeout_o <= 1'b1;
                result_class_o <= '0;
                result_pass_o <= 1'b0;
            end
            if (state == EVAL) begin
                result_class_o <= amax;
                result_pass_o <= amax == label;
            end
            if (res_acc) begin
                img <= last_img ? '0 : img + 1'b1;
                if (result_pass_o && pass_count_o != 16'hFFFF) pass_count_o <= pass_count_o + 16'd1;
                if (!result_pass_o && fail_count_o != 16'hFFFF) fail_count_o <= fail_count_o + 16'd1;
            end
        end
    end
endmodule
